// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Independent safety monitor on the receive side of the signal-head bus of
// traffic_controller_fsm. It sits between the controller and the lamp drivers.
// Each clock it decodes the four ASCII light codes, state_out and
// violation_warning, checks the phase-safety rules, latches the first fault
// and asks the lamp drivers for a forced all-flash. It also counts
// NORMAL->VIOLATION events.
//
// Pipeline:
//   stage 1 (edge N)   : register every input and decode the light codes
//                        (road_state is valid after edge N)
//   stage 2 (edge N+1) : evaluate the rules on stage-1 data against the
//                        previous stage-1 data and update the monitor FSM
//                        (fault / fault_code are valid after edge N+1)
//
// Ports:
//   clk                 in   clock
//   reset               in   asynchronous, active-high reset
//   R1_light..R4_light  in   24-bit ASCII light code per road
//   state_out           in   controller state (0 = controller restart state)
//   violation_warning   in   72-bit ASCII "VIOLATION" / "NORMAL"
//   night_mode          in   night flash active, excuses transition rules
//   preempt             in   OR of ambulance requests, excuses transition rules
//   clear_req           in   single-cycle fault-clear request
//   fault               out  fault latched
//   fault_code          out  0 NONE, 1 CONFLICT, 2 INVALID, 3 SKIP_YELLOW,
//                            4 SHORT_YELLOW
//   flash_req           out  force all-flash request to the lamp drivers
//   road_state          out  3 bits per road, R1 in [2:0]:
//                            0 RED, 1 YEL, 2 GRN, 3 DARK, 4 INV
//   viol_count          out  saturating count of NORMAL->VIOLATION edges
//   mon_state           out  monitor FSM state: 0 ARMED, 1 FAULT, 2 RECOVER
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter logic [31:0] MIN_YELLOW = 32'd3000000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      R1_light,
    input  logic [23:0]      R2_light,
    input  logic [23:0]      R3_light,
    input  logic [23:0]      R4_light,
    input  logic [3:0]       state_out,
    input  logic [71:0]      violation_warning,
    input  logic             night_mode,
    input  logic             preempt,
    input  logic             clear_req,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             flash_req,
    output logic [11:0]      road_state,
    output logic [CNT_W-1:0] viol_count,
    output logic [1:0]       mon_state
);

    typedef enum logic [2:0] {
        LT_RED  = 3'd0,
        LT_YEL  = 3'd1,
        LT_GRN  = 3'd2,
        LT_DARK = 3'd3,
        LT_INV  = 3'd4
    } light_t;

    typedef enum logic [1:0] {
        MON_ARMED   = 2'd0,
        MON_FAULT   = 2'd1,
        MON_RECOVER = 2'd2
    } mon_t;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_CONFLICT = 3'd1;
    localparam logic [2:0] CODE_INVALID  = 3'd2;
    localparam logic [2:0] CODE_SKIP_YEL = 3'd3;
    localparam logic [2:0] CODE_SHORT_YEL = 3'd4;

    localparam logic [71:0] VW_VIOLATION = 72'h56494F4C4154494F4E;
    localparam logic [71:0] VW_NORMAL    = 72'h00_0000_4E4F524D414C;

    function automatic light_t decode_light(input logic [23:0] code);
        light_t res;
        case (code)
            24'h000052: res = LT_RED;
            24'h000059: res = LT_YEL;
            24'h000047: res = LT_GRN;
            24'h000000: res = LT_DARK;
            default:    res = LT_INV;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Stage 1: registered inputs and decoded light codes
    // -----------------------------------------------------------------------
    logic [23:0] light_in [4];
    assign light_in[0] = R1_light;
    assign light_in[1] = R2_light;
    assign light_in[2] = R3_light;
    assign light_in[3] = R4_light;

    light_t      light_q [4];
    logic [3:0]  state_out_q;
    logic        vw_viol_q;
    logic        vw_norm_q;
    logic        night_q;
    logic        preempt_q;
    logic        clear_q;
    // Stage-1 registers hold real bus data (not reset values) once this is set.
    logic        s1_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) light_q[i] <= LT_RED;
            state_out_q <= 4'd0;
            vw_viol_q   <= 1'b0;
            vw_norm_q   <= 1'b0;
            night_q     <= 1'b0;
            preempt_q   <= 1'b0;
            clear_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) light_q[i] <= decode_light(light_in[i]);
            state_out_q <= state_out;
            vw_viol_q   <= (violation_warning == VW_VIOLATION);
            vw_norm_q   <= (violation_warning == VW_NORMAL);
            night_q     <= night_mode;
            preempt_q   <= preempt;
            clear_q     <= clear_req;
            s1_valid_q  <= 1'b1;
        end
    end

    assign road_state = {light_q[3], light_q[2], light_q[1], light_q[0]};

    // -----------------------------------------------------------------------
    // Stage 2 history: previous decoded lights and yellow run lengths
    // -----------------------------------------------------------------------
    light_t      prev_q [4];
    logic        prev_valid_q;
    logic [31:0] yel_cnt_q [4];
    logic        leave_recover;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i]    <= LT_RED;
                yel_cnt_q[i] <= 32'd0;
            end
            prev_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i] <= light_q[i];
                // Counts stage-1 YEL samples, so at a YEL->RED transition the
                // value read by the rule logic is the full yellow run length.
                if (s1_valid_q && light_q[i] == LT_YEL) begin
                    if (yel_cnt_q[i] != 32'hFFFF_FFFF) begin
                        yel_cnt_q[i] <= yel_cnt_q[i] + 32'd1;
                    end
                end else begin
                    yel_cnt_q[i] <= 32'd0;
                end
            end
            // History restarts after RECOVER: the sample taken on the exit
            // edge becomes the first valid "previous" one.
            prev_valid_q <= leave_recover ? 1'b0 : s1_valid_q;
        end
    end

    // -----------------------------------------------------------------------
    // Rule evaluation
    // -----------------------------------------------------------------------
    logic [2:0] n_grn;
    logic       any_inv;
    logic       hit_conflict;
    logic       hit_invalid;
    logic       hit_skip;
    logic       hit_short;
    logic       hard_hit;
    logic [2:0] hard_code;
    logic [2:0] hit_code;

    always_comb begin
        n_grn    = 3'd0;
        any_inv  = 1'b0;
        hit_skip = 1'b0;
        hit_short = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (light_q[i] == LT_GRN) n_grn = n_grn + 3'd1;
            if (light_q[i] == LT_INV) any_inv = 1'b1;
            if (prev_valid_q && !preempt_q && !night_q) begin
                if (prev_q[i] == LT_GRN && light_q[i] != LT_GRN &&
                    light_q[i] != LT_YEL) begin
                    hit_skip = 1'b1;
                end
                if (prev_q[i] == LT_YEL && light_q[i] == LT_RED &&
                    yel_cnt_q[i] < MIN_YELLOW) begin
                    hit_short = 1'b1;
                end
            end
        end
        hit_conflict = s1_valid_q && (n_grn >= 3'd2);
        hit_invalid  = s1_valid_q && (any_inv || !(vw_viol_q || vw_norm_q));
        hard_hit     = hit_conflict || hit_invalid;

        // Lowest nonzero code wins when several rules fire together.
        hard_code = CODE_NONE;
        if (hit_conflict)     hard_code = CODE_CONFLICT;
        else if (hit_invalid) hard_code = CODE_INVALID;

        hit_code = hard_code;
        if (hard_code == CODE_NONE) begin
            if (hit_skip)       hit_code = CODE_SKIP_YEL;
            else if (hit_short) hit_code = CODE_SHORT_YEL;
        end
    end

    // -----------------------------------------------------------------------
    // Monitor FSM with registered outputs
    // -----------------------------------------------------------------------
    mon_t       mon_q;
    logic       fault_q;
    logic [2:0] fault_code_q;
    logic       flash_q;

    assign leave_recover = (mon_q == MON_RECOVER) && !hard_hit &&
                           s1_valid_q && (state_out_q == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mon_q        <= MON_ARMED;
            fault_q      <= 1'b0;
            fault_code_q <= CODE_NONE;
            flash_q      <= 1'b0;
        end else begin
            case (mon_q)
                MON_ARMED: begin
                    if (hit_code != CODE_NONE) begin
                        mon_q        <= MON_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= hit_code;
                        flash_q      <= 1'b1;
                    end
                end
                MON_FAULT: begin
                    // First fault code is held; a clear is refused while the
                    // bus still shows a conflict or an invalid code.
                    if (clear_q && !hard_hit) begin
                        mon_q        <= MON_RECOVER;
                        fault_q      <= 1'b0;
                        fault_code_q <= CODE_NONE;
                    end
                end
                MON_RECOVER: begin
                    if (hard_hit) begin
                        mon_q        <= MON_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= hard_code;
                        flash_q      <= 1'b1;
                    end else if (leave_recover) begin
                        mon_q   <= MON_ARMED;
                        flash_q <= 1'b0;
                    end
                end
                default: begin
                    mon_q        <= MON_ARMED;
                    fault_q      <= 1'b0;
                    fault_code_q <= CODE_NONE;
                    flash_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign flash_req  = flash_q;
    assign mon_state  = mon_q;

    // -----------------------------------------------------------------------
    // Violation event counter (independent of the monitor state)
    // -----------------------------------------------------------------------
    logic             prev_norm_q;
    logic [CNT_W-1:0] viol_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_norm_q <= 1'b0;
            viol_cnt_q  <= '0;
        end else begin
            prev_norm_q <= vw_norm_q;
            if (prev_norm_q && vw_viol_q && (viol_cnt_q != {CNT_W{1'b1}})) begin
                viol_cnt_q <= viol_cnt_q + CNT_W'(1);
            end
        end
    end

    assign viol_count = viol_cnt_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

  localparam int W = 35;

  localparam logic [23:0] L_R = 24'h000052;
  localparam logic [23:0] L_Y = 24'h000059;
  localparam logic [23:0] L_G = 24'h000047;
  localparam logic [23:0] L_BAD = 24'h000041;
  localparam logic [71:0] VW_NORM = 72'h00_0000_4E4F524D414C;
  localparam logic [71:0] VW_VIOL = 72'h56494F4C4154494F4E;
  localparam logic [71:0] VW_XYZ  = 72'h58595A;

  localparam logic [1:0] M_ARM = 2'd0;
  localparam logic [1:0] M_FLT = 2'd1;
  localparam logic [1:0] M_REC = 2'd2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] r1, r2, r3, r4;
  logic [3:0]  state_out;
  logic [71:0] vw;
  logic        night_mode, preempt, clear_req;
  logic        fault, flash_req;
  logic [2:0]  fault_code;
  logic [11:0] road_state;
  logic [15:0] viol_count;
  logic [1:0]  mon_state;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(.MIN_YELLOW(32'd3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .R1_light(r1), .R2_light(r2), .R3_light(r3), .R4_light(r4),
    .state_out(state_out), .violation_warning(vw),
    .night_mode(night_mode), .preempt(preempt), .clear_req(clear_req),
    .fault(fault), .fault_code(fault_code), .flash_req(flash_req),
    .road_state(road_state), .viol_count(viol_count), .mon_state(mon_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  string        name_q[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  // Expected output word is due 'ahead' rising edges after the current one.
  task automatic expect_out(input string nm, input int ahead, input logic [1:0] ms,
                            input logic f, input logic [2:0] c, input logic fl,
                            input logic [15:0] vc, input logic [11:0] rs);
    exp_q.push_back({ms, f, c, fl, vc, rs});
    due_q.push_back(cyc + ahead);
    name_q.push_back(nm);
  endtask

  // Monitor: after each rising edge, pop and compare every entry that is due.
  initial begin
    forever begin
      logic [W-1:0] got, exp;
      int           due;
      string        nm;
      @(posedge clk);
      cyc++;
      #1;
      got = {mon_state, fault, fault_code, flash_req, viol_count, road_state};
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        exp = exp_q.pop_front();
        due = due_q.pop_front();
        nm  = name_q.pop_front();
        total++;
        if (due != cyc || got !== exp) begin
          bad++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h (ms,f,code,fl,vc,rs)",
                   nm, cyc, due, got, exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lights(input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] c, input logic [23:0] d);
    r1 = a; r2 = b; r3 = c; r4 = d;
  endtask

  // Clear the fault, then release RECOVER with a state_out==0 sample.
  task automatic do_recover(input string nm, input logic [15:0] vc);
    clear_req = 1'b1;
    expect_out({nm, "_recover"}, 2, M_REC, 1'b0, 3'd0, 1'b1, vc, 12'h000);
    wait_n(1);
    clear_req = 1'b0;
    wait_n(3);
    state_out = 4'd0;
    expect_out({nm, "_armed"}, 2, M_ARM, 1'b0, 3'd0, 1'b0, vc, 12'h000);
    wait_n(1);
    state_out = 4'd1;
    wait_n(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset = 1'b1;
    lights(L_R, L_R, L_R, L_R);
    state_out = 4'd1; vw = VW_NORM;
    night_mode = 1'b0; preempt = 1'b0; clear_req = 1'b0;

    expect_out("reset_state", 2, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    wait_n(3);
    reset = 1'b0;
    expect_out("after_reset", 3, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    wait_n(4);

    // 1: legal R1 cycle, yellow exactly MIN_YELLOW long
    lights(L_G, L_R, L_R, L_R);
    expect_out("t1_green", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h002);
    expect_out("t1_green_hold", 20, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h002);
    wait_n(41);
    lights(L_Y, L_R, L_R, L_R);
    expect_out("t1_yellow", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h001);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    expect_out("t1_red", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    expect_out("t1_no_fault", 3, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    wait_n(4);
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL t1_direct fault=%b", fault);
    end

    // 2: R1 and R3 green together; clear refused while the conflict lasts
    lights(L_G, L_R, L_G, L_R);
    expect_out("t2_rs", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h082);
    expect_out("t2_conflict", 2, M_FLT, 1'b1, 3'd1, 1'b1, 16'd0, 12'h082);
    wait_n(3);
    total++;
    if (fault_code !== 3'd1) begin
      bad++;
      $display("FAIL t2_direct fault_code=%0d", fault_code);
    end
    clear_req = 1'b1;
    wait_n(1);
    clear_req = 1'b0;
    expect_out("t5_clear_ignored", 2, M_FLT, 1'b1, 3'd1, 1'b1, 16'd0, 12'h082);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    expect_out("t2_held", 2, M_FLT, 1'b1, 3'd1, 1'b1, 16'd0, 12'h000);
    wait_n(3);
    do_recover("t5", 16'd0);

    // 3: R2 green straight to red, then the same with preempt
    lights(L_R, L_G, L_R, L_R);
    expect_out("t3_r2_grn", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h010);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    expect_out("t3_skip", 2, M_FLT, 1'b1, 3'd3, 1'b1, 16'd0, 12'h000);
    wait_n(3);
    do_recover("t3", 16'd0);
    preempt = 1'b1;
    lights(L_R, L_G, L_R, L_R);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    expect_out("t3_preempt_ok", 3, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    wait_n(4);
    preempt = 1'b0;
    wait_n(2);

    // 4: R4 yellow only 2 cycles; a later conflict keeps the first code
    lights(L_R, L_R, L_R, L_G);
    expect_out("t4_r4_grn", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h400);
    wait_n(3);
    lights(L_R, L_R, L_R, L_Y);
    expect_out("t4_r4_yel", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h200);
    wait_n(2);
    lights(L_R, L_R, L_R, L_R);
    expect_out("t4_short", 2, M_FLT, 1'b1, 3'd4, 1'b1, 16'd0, 12'h000);
    wait_n(3);
    lights(L_G, L_R, L_G, L_R);
    expect_out("t4_code_held", 2, M_FLT, 1'b1, 3'd4, 1'b1, 16'd0, 12'h082);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    wait_n(3);
    do_recover("t4", 16'd0);

    // 6: three NORMAL->VIOLATION edges, then an unknown warning string
    for (int i = 1; i <= 3; i++) begin
      vw = VW_VIOL;
      expect_out("t6_count", 2, M_ARM, 1'b0, 3'd0, 1'b0, 16'(i), 12'h000);
      wait_n(2);
      vw = VW_NORM;
      wait_n(2);
    end
    total++;
    if (viol_count !== 16'd3) begin
      bad++;
      $display("FAIL t6_direct viol_count=%0d", viol_count);
    end
    vw = VW_XYZ;
    expect_out("t6_invalid_vw", 2, M_FLT, 1'b1, 3'd2, 1'b1, 16'd3, 12'h000);
    wait_n(3);
    vw = VW_NORM;
    wait_n(3);
    do_recover("t6", 16'd3);

    // unknown light code on R2
    lights(L_R, L_BAD, L_R, L_R);
    expect_out("inv_light", 2, M_FLT, 1'b1, 3'd2, 1'b1, 16'd3, 12'h020);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    wait_n(3);
    do_recover("inv", 16'd3);

    // night mode excuses a skipped yellow
    night_mode = 1'b1;
    lights(L_G, L_R, L_R, L_R);
    wait_n(3);
    lights(L_R, L_R, L_R, L_R);
    expect_out("night_ok", 3, M_ARM, 1'b0, 3'd0, 1'b0, 16'd3, 12'h000);
    wait_n(4);
    night_mode = 1'b0;
    wait_n(2);

    // reset in the middle of FAULT clears everything, including viol_count
    lights(L_G, L_R, L_G, L_R);
    expect_out("rst_pre_fault", 2, M_FLT, 1'b1, 3'd1, 1'b1, 16'd3, 12'h082);
    wait_n(3);
    reset = 1'b1;
    expect_out("rst_mid_fault", 1, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    wait_n(2);
    total++;
    if (fault !== 1'b0 || viol_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_direct fault=%b viol_count=%0d", fault, viol_count);
    end
    lights(L_R, L_R, L_R, L_R);
    wait_n(1);
    reset = 1'b0;
    expect_out("rst_after", 3, M_ARM, 1'b0, 3'd0, 1'b0, 16'd0, 12'h000);
    wait_n(4);

    // drain the scoreboard with a bounded wait
    guard = 0;
    while (due_q.size() > 0 && guard < 50) begin
      wait_n(1);
      guard++;
    end
    while (due_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      total++;
      bad++;
      $display("FAIL %s never checked", name_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
